// File: rtl/scope_pkg.sv
// ----------------------------------------------------------------------------
// scope_pkg
//   Shared definitions for the scope capture path and the VGA trace renderer:
//   default buffer geometry, capture FSM state encoding and scope mode codes.
// ----------------------------------------------------------------------------
package scope_pkg;

   // Default geometry, also used by the VGA renderer
   localparam int unsigned SCOPE_SAMPLE_W = 12;
   localparam int unsigned SCOPE_ADDR_W   = 10;
   localparam int unsigned SCOPE_DEPTH    = 640;

   // Capture FSM state; the encoding is visible on state_o / HEX display
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_DONE  = 3'd4
   } cap_state_t;

   // Scope run mode as written by software into cfg_mode
   typedef enum logic [1:0] {
      MODE_AUTO   = 2'd0,
      MODE_NORMAL = 2'd1,
      MODE_SINGLE = 2'd2,
      MODE_STOP   = 2'd3
   } scope_mode_t;

   // Modes that re-arm by themselves without a cfg_arm pulse
   function automatic logic is_free_run(input scope_mode_t m);
      return (m == MODE_AUTO) || (m == MODE_NORMAL);
   endfunction

endpackage

// File: rtl/scope_trig_detect.sv
// ----------------------------------------------------------------------------
// scope_trig_detect
//   Decimation counter, previous-accepted-sample register and edge compare.
//   Ports:
//     clk, reset    : clock, asynchronous active-high reset
//     active        : capture is running (FILL/ARMED/POST); gates counting
//     restart       : capture (re)starts next cycle; clears the decimation
//                     counter and suppresses a trigger on the first sample
//     sample_valid  : ADC strobe
//     sample_data   : ADC code
//     level, rising : latched trigger level and polarity
//     decim         : latched decimation (keep 1 of decim+1 strobes)
//     accept        : this strobe is an accepted (kept) sample
//     trig_hit      : accepted sample crosses the level against the previous
//                     accepted sample
// ----------------------------------------------------------------------------
module scope_trig_detect
   import scope_pkg::*;
#(
   parameter int unsigned SAMPLE_W = SCOPE_SAMPLE_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                active,
   input  logic                restart,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample_data,
   input  logic [SAMPLE_W-1:0] level,
   input  logic                rising,
   input  logic [7:0]          decim,
   output logic                accept,
   output logic                trig_hit
);

   logic [7:0]          dec_cnt;
   logic [SAMPLE_W-1:0] prev;
   logic                first;
   logic                edge_hit;

   always_comb begin
      accept = active && sample_valid && (dec_cnt == decim);
      if (rising)
         edge_hit = (prev < level) && (sample_data >= level);
      else
         edge_hit = (prev > level) && (sample_data <= level);
      // prev is meaningless for the first sample of a capture
      trig_hit = accept && !first && edge_hit;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dec_cnt <= '0;
         prev    <= '0;
         first   <= 1'b1;
      end else if (restart) begin
         dec_cnt <= '0;
         first   <= 1'b1;
      end else if (active && sample_valid) begin
         if (dec_cnt == decim) begin
            dec_cnt <= '0;
            prev    <= sample_data;
            first   <= 1'b0;
         end else begin
            dec_cnt <= dec_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/scope_capture_ctrl.sv
// ----------------------------------------------------------------------------
// scope_capture_ctrl
//   Writes decimated ADC samples into the circular sample RAM, keeps PRETRIG
//   samples of history before the trigger and announces one complete frame
//   of DEPTH samples per capture to the display.
//   Ports:
//     clk, reset         : clock, asynchronous active-high reset
//     sample_valid/data  : ADC sample stream
//     cfg_trig_level     : trigger threshold
//     cfg_trig_rising    : 1 = rising edge, 0 = falling edge
//     cfg_decim          : keep 1 of every cfg_decim+1 strobes
//     cfg_mode           : 0 auto, 1 normal, 2 single, 3 stop
//     cfg_arm            : start a capture in single mode (IDLE only)
//     disp_busy          : display is reading the buffer; hold in DONE
//     buf_we/waddr/wdata : registered sample RAM write port
//     frame_start        : address of the oldest sample of the last frame
//     frame_done         : one-cycle pulse, new frame complete
//     triggered          : 1 = real edge, 0 = auto timeout
//     state_o            : FSM state encoding for debug
// ----------------------------------------------------------------------------
module scope_capture_ctrl
   import scope_pkg::*;
#(
   parameter int unsigned SAMPLE_W = SCOPE_SAMPLE_W,
   parameter int unsigned ADDR_W   = SCOPE_ADDR_W,
   parameter int unsigned DEPTH    = SCOPE_DEPTH,
   parameter int unsigned PRETRIG  = 160,
   parameter int unsigned AUTO_TO  = 4096
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample_data,
   input  logic [SAMPLE_W-1:0] cfg_trig_level,
   input  logic                cfg_trig_rising,
   input  logic [7:0]          cfg_decim,
   input  logic [1:0]          cfg_mode,
   input  logic                cfg_arm,
   input  logic                disp_busy,
   output logic                buf_we,
   output logic [ADDR_W-1:0]   buf_waddr,
   output logic [SAMPLE_W-1:0] buf_wdata,
   output logic [ADDR_W-1:0]   frame_start,
   output logic                frame_done,
   output logic                triggered,
   output logic [2:0]          state_o
);

   localparam int unsigned POST_LEN = DEPTH - PRETRIG;
   localparam int unsigned TO_W     = $clog2(AUTO_TO + 1);

   cap_state_t          state;
   scope_mode_t         live_mode;
   scope_mode_t         lat_mode;
   logic [SAMPLE_W-1:0] lat_level;
   logic                lat_rising;
   logic [7:0]          lat_decim;

   logic [ADDR_W-1:0]   wptr;
   logic [ADDR_W-1:0]   wptr_next;
   logic [ADDR_W-1:0]   trig_addr;
   logic [ADDR_W-1:0]   t_src;
   logic [ADDR_W-1:0]   fill_cnt;
   logic [ADDR_W-1:0]   post_cnt;
   logic [ADDR_W-1:0]   fs_calc;
   logic [ADDR_W:0]     fs_sum;
   logic [TO_W-1:0]     to_cnt;

   logic                active;
   logic                start_cap;
   logic                stop;
   logic                wr_en;
   logic                forced;
   logic                accept;
   logic                trig_hit;

   scope_trig_detect #(
      .SAMPLE_W (SAMPLE_W)
   ) u_trig (
      .clk          (clk),
      .reset        (reset),
      .active       (active),
      .restart      (start_cap),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .level        (lat_level),
      .rising       (lat_rising),
      .decim        (lat_decim),
      .accept       (accept),
      .trig_hit     (trig_hit)
   );

   always_comb begin
      live_mode = scope_mode_t'(cfg_mode);
      stop      = (live_mode == MODE_STOP);
      active    = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST);

      // start_cap marks the cycle on which a new capture begins (IDLE/DONE exit)
      start_cap = 1'b0;
      case (state)
         ST_IDLE: start_cap = is_free_run(live_mode) ||
                              ((live_mode == MODE_SINGLE) && cfg_arm);
         ST_DONE: start_cap = !disp_busy && is_free_run(live_mode);
         default: start_cap = 1'b0;
      endcase

      // A stop request wins over a sample arriving on the same cycle
      wr_en  = active && accept && !stop;
      forced = (lat_mode == MODE_AUTO) && (to_cnt == TO_W'(AUTO_TO));

      wptr_next = (wptr == ADDR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;

      // (T - PRETRIG) mod DEPTH computed as (T + DEPTH - PRETRIG) mod DEPTH;
      // T comes straight from wptr when the trigger sample is also the last
      t_src   = (state == ST_ARMED) ? wptr : trig_addr;
      fs_sum  = {1'b0, t_src} + (ADDR_W + 1)'(POST_LEN);
      fs_calc = (fs_sum >= (ADDR_W + 1)'(DEPTH)) ?
                ADDR_W'(fs_sum - (ADDR_W + 1)'(DEPTH)) : fs_sum[ADDR_W-1:0];
   end

   assign state_o = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         lat_mode    <= MODE_AUTO;
         lat_level   <= '0;
         lat_rising  <= 1'b0;
         lat_decim   <= '0;
         wptr        <= '0;
         trig_addr   <= '0;
         fill_cnt    <= '0;
         post_cnt    <= '0;
         to_cnt      <= '0;
         buf_we      <= 1'b0;
         buf_waddr   <= '0;
         buf_wdata   <= '0;
         frame_start <= '0;
         frame_done  <= 1'b0;
         triggered   <= 1'b0;
      end else begin
         buf_we     <= wr_en;
         frame_done <= 1'b0;

         if (wr_en) begin
            buf_waddr <= wptr;
            buf_wdata <= sample_data;
            wptr      <= wptr_next;
         end

         if (start_cap) begin
            lat_mode   <= live_mode;
            lat_level  <= cfg_trig_level;
            lat_rising <= cfg_trig_rising;
            lat_decim  <= cfg_decim;
            fill_cnt   <= '0;
         end

         case (state)
            ST_IDLE: begin
               if (start_cap)
                  state <= ST_FILL;
            end

            ST_FILL: begin
               if (stop) begin
                  state <= ST_IDLE;
               end else if (accept) begin
                  if (fill_cnt == ADDR_W'(PRETRIG - 1)) begin
                     state  <= ST_ARMED;
                     to_cnt <= '0;
                  end else begin
                     fill_cnt <= fill_cnt + 1'b1;
                  end
               end
            end

            ST_ARMED: begin
               if (stop) begin
                  state <= ST_IDLE;
               end else if (accept) begin
                  if (trig_hit || forced) begin
                     trig_addr <= wptr;
                     triggered <= trig_hit;
                     post_cnt  <= ADDR_W'(1);
                     if (POST_LEN == 1) begin
                        frame_start <= fs_calc;
                        frame_done  <= 1'b1;
                        state       <= ST_DONE;
                     end else begin
                        state <= ST_POST;
                     end
                  end else if (to_cnt != TO_W'(AUTO_TO)) begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end
            end

            ST_POST: begin
               if (stop) begin
                  state <= ST_IDLE;
               end else if (accept) begin
                  if (post_cnt == ADDR_W'(POST_LEN - 1)) begin
                     frame_start <= fs_calc;
                     frame_done  <= 1'b1;
                     state       <= ST_DONE;
                  end else begin
                     post_cnt <= post_cnt + 1'b1;
                  end
               end
            end

            ST_DONE: begin
               if (!disp_busy)
                  state <= start_cap ? ST_FILL : ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
